// File: rtl/ks_note_sequencer_pkg.sv
// Shared widths, note-table anchor and FSM state encoding for the Karplus-Strong note sequencer.
package ks_note_sequencer_pkg;
  localparam int KS_LEN_W  = 11;
  localparam int KS_DATA_W = 24;
  localparam int KS_NOTE_W = 7;
  // Lowest note whose delay-line length still fits KS_LEN_W at 48 kHz.
  localparam int BASE_NOTE = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } ks_state_e;
endpackage

// File: rtl/ks_note_sequencer_if.sv
// Sequencer <-> Karplus-Strong engine handshake: start/newnote/length out, sample back.
interface ks_note_sequencer_if;
  import ks_note_sequencer_pkg::*;

  logic                        ks_start;
  logic                        ks_newnote;
  logic [KS_LEN_W-1:0]         ks_length;
  logic signed [KS_DATA_W-1:0] ks_dout;
  logic                        ks_dout_valid;

  modport master (output ks_start, ks_newnote, ks_length, input ks_dout, ks_dout_valid);
  modport slave  (input ks_start, ks_newnote, ks_length, output ks_dout, ks_dout_valid);
endinterface

// File: rtl/ks_note_sequencer_lut.sv
// Note number -> delay-line length, floor(48000 / f(note)); 0 below MIN_NOTE.
module ks_note_lut
  import ks_note_sequencer_pkg::*;
#(
  parameter int unsigned MIN_NOTE = 19
) (
  input  logic [KS_NOTE_W-1:0] note_num,
  output logic [KS_LEN_W-1:0]  length
);

  logic [KS_NOTE_W-1:0] rel;
  logic [KS_NOTE_W-1:0] oct;
  logic [KS_NOTE_W-1:0] idx;
  logic [KS_LEN_W-1:0]  base;

  // One octave of exact lengths; floor(x / 2^k) == floor(x) >> k keeps higher octaves exact.
  always_comb begin
    rel  = note_num - KS_NOTE_W'(BASE_NOTE);
    oct  = rel / KS_NOTE_W'(12);
    idx  = rel - oct * KS_NOTE_W'(12);
    base = '0;
    case (idx)
      7'd0:    base = 11'd1959;
      7'd1:    base = 11'd1849;
      7'd2:    base = 11'd1745;
      7'd3:    base = 11'd1647;
      7'd4:    base = 11'd1555;
      7'd5:    base = 11'd1467;
      7'd6:    base = 11'd1385;
      7'd7:    base = 11'd1307;
      7'd8:    base = 11'd1234;
      7'd9:    base = 11'd1164;
      7'd10:   base = 11'd1099;
      7'd11:   base = 11'd1037;
      default: base = '0;
    endcase
    length = '0;
    if (note_num >= KS_NOTE_W'(MIN_NOTE)) length = base >> oct;
  end

endmodule

// File: rtl/ks_note_sequencer.sv
// Drives one Karplus-Strong engine from note events and the I2S sample tick.
// Optional KS_SEQ_VELOCITY_EN adds a velocity input and one scaling stage on the output sample.
module ks_note_sequencer
  import ks_note_sequencer_pkg::*;
#(
  parameter int unsigned SUSTAIN_SAMPLES = 48000,
  parameter int unsigned TIMEOUT_CYC     = 4095,
  parameter int unsigned MIN_NOTE        = 19
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic                        note_on,
  input  logic                        note_off,
  input  logic [KS_NOTE_W-1:0]        note_num,
`ifdef KS_SEQ_VELOCITY_EN
  input  logic [KS_NOTE_W-1:0]        velocity,
`endif
  ks_note_sequencer_if.master         ks,
  output logic signed [KS_DATA_W-1:0] sample_out,
  output logic                        sample_valid,
  output logic                        active,
  output logic                        overrun,
  output logic                        timeout
);

  localparam int SUS_W = $clog2(SUSTAIN_SAMPLES + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  ks_state_e                   state_q, state_d;
  logic [KS_LEN_W-1:0]         len_q, len_d, nlen_q, nlen_d, lut_len;
  logic                        pend_new_q, pend_new_d, active_q, active_d, rel_q, rel_d;
  logic [SUS_W-1:0]            sus_q, sus_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic signed [KS_DATA_W-1:0] sample_out_q, sample_out_d;
  logic                        sample_valid_q, sample_valid_d;
  logic                        overrun_q, overrun_d, timeout_q, timeout_d;
  logic                        note_ok, rel_now;

  ks_note_lut #(.MIN_NOTE(MIN_NOTE)) u_lut (.note_num(note_num), .length(lut_len));

  assign note_ok = note_on && (note_num >= KS_NOTE_W'(MIN_NOTE));

`ifdef KS_SEQ_VELOCITY_EN
  logic signed [KS_DATA_W-1:0] cap_q, cap_d;
  logic [KS_NOTE_W-1:0]        vel_q, vel_d;

  function automatic logic signed [KS_DATA_W-1:0] vel_scale(input logic signed [KS_DATA_W-1:0] d,
                                                           input logic [KS_NOTE_W-1:0] v);
    logic signed [31:0] prod;
    logic signed [31:0] shr;
    prod = 32'(d) * 32'($signed({1'b0, v}));
    shr  = prod >>> 7;
    return shr[KS_DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    cap_q <= cap_d;
    vel_q <= vel_d;
  end
`endif

  always_comb begin
    state_d        = state_q;
    nlen_d         = nlen_q;
    len_d          = len_q;
    pend_new_d     = pend_new_q;
    active_d       = active_q;
    sus_d          = sus_q;
    tmo_d          = tmo_q;
    sample_out_d   = '0;
    sample_valid_d = 1'b0;
    timeout_d      = timeout_q;
    overrun_d      = overrun_q | (sample_tick & (state_q != ST_IDLE));
`ifdef KS_SEQ_VELOCITY_EN
    cap_d          = cap_q;
    vel_d          = vel_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          if (active_q) state_d = ST_START;
          else          sample_valid_d = 1'b1;
        end
      end
      ST_START: begin
        pend_new_d = 1'b0;
        tmo_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (ks.ks_dout_valid) begin
`ifdef KS_SEQ_VELOCITY_EN
          cap_d          = ks.ks_dout;
`else
          sample_valid_d = 1'b1;
          sample_out_d   = ks.ks_dout;
`endif
          state_d = ST_OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout_d      = 1'b1;
          sample_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_OUT: begin
`ifdef KS_SEQ_VELOCITY_EN
        sample_valid_d = 1'b1;
        sample_out_d   = vel_scale(cap_q, vel_q);
`endif
        sus_d   = sus_q + 1'b1;
        if ((SUSTAIN_SAMPLES != 0) && (sus_d == SUS_W'(SUSTAIN_SAMPLES))) active_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A release waits for the in-flight sample; a same-cycle note-on overrides it.
    rel_now = rel_q | note_off;
    rel_d   = rel_now;
    if (rel_now && (state_d == ST_IDLE)) begin
      active_d = 1'b0;
      rel_d    = 1'b0;
    end
    if (note_ok) begin
      nlen_d     = lut_len;
      pend_new_d = 1'b1;
      active_d   = 1'b1;
      rel_d      = 1'b0;
      sus_d      = '0;
`ifdef KS_SEQ_VELOCITY_EN
      vel_d      = velocity;
`endif
    end
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) len_d = nlen_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      nlen_q         <= '0;
      pend_new_q     <= 1'b0;
      active_q       <= 1'b0;
      rel_q          <= 1'b0;
      sus_q          <= '0;
      tmo_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      nlen_q         <= nlen_d;
      pend_new_q     <= pend_new_d;
      active_q       <= active_d;
      rel_q          <= rel_d;
      sus_q          <= sus_d;
      tmo_q          <= tmo_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  assign ks.ks_start   = (state_q == ST_START);
  assign ks.ks_newnote = (state_q == ST_START) && pend_new_q;
  assign ks.ks_length  = len_q;
  assign sample_out    = sample_out_q;
  assign sample_valid  = sample_valid_q;
  assign active        = active_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;

endmodule
